// File: rtl/cdce_spi_pkg.sv
// Shared types and constants for the CDCE62005 SPI responder.
// Holds the command encodings, the word geometry and the register power-on values.
package cdce_spi_pkg;

    localparam int WORD_W = 32;
    localparam int DATA_W = 28;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] CMD_READ   = 4'hE;
    localparam logic [WORD_W-1:0] CMD_EEPROM = 32'h0000001F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DECODE
    } state_t;

    // Power-on register contents; indices past the physical map read as zero.
    function automatic logic [DATA_W-1:0] reg_default(input int idx);
        case (idx)
            0:       return 28'h8150310;
            1:       return 28'h8140301;
            2:       return 28'h8140302;
            3:       return 28'h8140303;
            4:       return 28'hEB40314;
            5:       return 28'h101C0BE;
            6:       return 28'h04BE19A;
            7:       return 28'hBD0037F;
            8:       return 28'h20009D9;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/cdce62005_spi_responder_if.sv
// SPI pin bundle between the CDCE62005 config master and the responder.
interface cdce62005_spi_responder_if;
    logic spi_clk;
    logic spi_mosi;
    logic spi_le;
    logic spi_miso;

    modport master (output spi_clk, output spi_mosi, output spi_le, input spi_miso);
    modport slave  (input spi_clk, input spi_mosi, input spi_le, output spi_miso);
endinterface

// File: rtl/cdce_spi_pin_sync.sv
// Synchronizer plus single-clock rise/fall detect for one SPI pin.
// RST_VAL is the pin's idle level so reset does not manufacture an edge.
module cdce_spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;
endmodule

// File: rtl/cdce62005_spi_responder.sv
// SPI target emulating the CDCE62005 register interface (32-bit LSB-first, LE-framed words).
// Optional EEPROM-copy emulation is enabled by defining CDCE_RSP_EEPROM_EN.
module cdce62005_spi_responder
    import cdce_spi_pkg::*;
#(
    parameter int NUM_REGS           = 9,
    parameter int SYNC_STAGES        = 2,
    parameter int EEPROM_BUSY_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    cdce62005_spi_responder_if.slave  spi,
    output logic                      reg_wr_stb,
    output logic [ADDR_W-1:0]         reg_wr_addr,
    output logic [DATA_W-1:0]         reg_wr_data,
    input  logic [ADDR_W-1:0]         host_rd_addr,
    output logic [DATA_W-1:0]         host_rd_data,
    output logic                      frame_err,
    output logic                      eeprom_busy
);
    logic sclk_level, sclk_rise, sclk_fall;
    logic le_level, le_rise, le_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    cdce_spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin(spi.spi_clk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    cdce_spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_le (
        .clk(clk), .rst(rst), .pin(spi.spi_le),
        .level(le_level), .rise(le_rise), .fall(le_fall)
    );
    cdce_spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .pin(spi.spi_mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_level, le_level, mosi_rise, mosi_fall};

    state_t              state;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [5:0]          bit_cnt;
    logic [WORD_W-1:0]   rx_sr;
    logic [WORD_W-1:0]   tx_sr;
    logic                pending_rd;
    logic                rd_frame;
    logic [ADDR_W-1:0]   rd_addr;
    logic                miso_q;

    logic                frame_start;
    logic                shift_active;
    logic [WORD_W-1:0]   tx_base;
    logic [WORD_W-1:0]   tx_next;
    logic [5:0]          bit_base;
    logic [5:0]          bit_next;

    function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) ? regs[a] : '0;
    endfunction

`ifdef CDCE_RSP_EEPROM_EN
    localparam int BUSY_W = $clog2(EEPROM_BUSY_CYCLES + 1);

    // Shadow array and its valid flag deliberately survive rst, like a real EEPROM.
    logic [DATA_W-1:0]   eeprom [NUM_REGS-1];
    logic                ee_valid;
    logic                busy_q;
    logic [BUSY_W-1:0]   busy_cnt;

    assign eeprom_busy = busy_q;
`else
    assign eeprom_busy = 1'b0;
`endif

    // LE fall is applied first, so an SCLK edge in the same clk acts on the fresh frame.
    always_comb begin
        frame_start  = (state == IDLE) && le_fall;
        shift_active = frame_start || (state == SHIFT);
        tx_base      = tx_sr;
        if (frame_start)
            tx_base = pending_rd ? {reg_at(rd_addr), rd_addr} : '0;
        tx_next  = sclk_fall ? (tx_base >> 1) : tx_base;
        bit_base = frame_start ? 6'd0 : bit_cnt;
        bit_next = (sclk_rise && bit_base != 6'd63) ? bit_base + 6'd1 : bit_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            pending_rd  <= 1'b0;
            rd_frame    <= 1'b0;
            rd_addr     <= '0;
            miso_q      <= 1'b0;
            reg_wr_stb  <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            frame_err   <= 1'b0;
`ifdef CDCE_RSP_EEPROM_EN
            busy_q      <= 1'b0;
            busy_cnt    <= '0;
            for (int i = 0; i < NUM_REGS - 1; i++)
                regs[i] <= ee_valid ? eeprom[i] : reg_default(i);
            regs[NUM_REGS-1] <= reg_default(NUM_REGS - 1);
`else
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= reg_default(i);
`endif
        end else begin
            reg_wr_stb <= 1'b0;
            frame_err  <= 1'b0;
`ifdef CDCE_RSP_EEPROM_EN
            if (busy_q) begin
                if (busy_cnt == '0)
                    busy_q <= 1'b0;
                else
                    busy_cnt <= busy_cnt - 1'b1;
            end
`endif
            if (shift_active) begin
                tx_sr   <= tx_next;
                miso_q  <= tx_next[0];
                bit_cnt <= bit_next;
                if (sclk_rise)
                    rx_sr <= {mosi_level, rx_sr[WORD_W-1:1]};
            end

            case (state)
                IDLE: begin
                    if (le_fall) begin
                        state    <= SHIFT;
                        rd_frame <= pending_rd;
                    end
                end
                SHIFT: begin
                    if (le_rise)
                        state <= DECODE;
                end
                DECODE: begin
                    state  <= IDLE;
                    miso_q <= 1'b0;
                    if (bit_cnt != 6'd32) begin
                        frame_err  <= 1'b1;
                        pending_rd <= 1'b0;
                    end else if (rd_frame) begin
                        pending_rd <= 1'b0;
                    end else if (32'(rx_sr[ADDR_W-1:0]) < NUM_REGS) begin
                        if (eeprom_busy) begin
                            frame_err <= 1'b1;
                        end else begin
                            regs[rx_sr[ADDR_W-1:0]] <= rx_sr[WORD_W-1:ADDR_W];
                            reg_wr_stb  <= 1'b1;
                            reg_wr_addr <= rx_sr[ADDR_W-1:0];
                            reg_wr_data <= rx_sr[WORD_W-1:ADDR_W];
                        end
                    end else if (rx_sr[ADDR_W-1:0] == CMD_READ) begin
                        rd_addr    <= rx_sr[7:4];
                        pending_rd <= 1'b1;
                    end else if (rx_sr == CMD_EEPROM) begin
`ifdef CDCE_RSP_EEPROM_EN
                        if (busy_q) begin
                            frame_err <= 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_REGS - 1; i++)
                                eeprom[i] <= regs[i];
                            ee_valid <= 1'b1;
                            busy_q   <= 1'b1;
                            busy_cnt <= BUSY_W'(EEPROM_BUSY_CYCLES - 1);
                        end
`else
                        frame_err <= 1'b1;
`endif
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spi.spi_miso = miso_q;
    assign host_rd_data = reg_at(host_rd_addr);
endmodule

// File: tb/tb_cdce62005_spi_responder.sv
// Bench for cdce62005_spi_responder: directed vector table, random frames against a
// rule-level register model, then EEPROM-copy and mid-frame reset sequences.
module tb_cdce62005_spi_responder;
    import cdce_spi_pkg::*;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr_stb;
    logic [3:0]  reg_wr_addr;
    logic [27:0] reg_wr_data;
    logic [3:0]  host_rd_addr;
    logic [27:0] host_rd_data;
    logic        frame_err;
    logic        eeprom_busy;

    cdce62005_spi_responder_if spi_bus();

    cdce62005_spi_responder dut (
        .clk          (clk),
        .rst          (rst),
        .spi          (spi_bus),
        .reg_wr_stb   (reg_wr_stb),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .frame_err    (frame_err),
        .eeprom_busy  (eeprom_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          stb_cnt = 0;
    int          err_cnt = 0;
    logic [3:0]  last_addr = '0;
    logic [27:0] last_data = '0;

    always @(negedge clk) begin
        if (reg_wr_stb) begin
            stb_cnt   = stb_cnt + 1;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
        if (frame_err)
            err_cnt = err_cnt + 1;
    end

    // Register-map model: plain arrays updated by the documented frame rules.
    logic [27:0] m_regs [9];
    bit          m_pend;
    logic [3:0]  m_addr;
    bit          m_busy;
    logic [27:0] m_ee [8];
    bit          m_ee_valid;

    function automatic logic [27:0] m_rd(input logic [3:0] a);
        return (a <= 4'd8) ? m_regs[a] : 28'h0;
    endfunction

    task automatic model_reset();
        m_pend = 1'b0;
        m_busy = 1'b0;
        for (int i = 0; i < 9; i++) begin
`ifdef CDCE_RSP_EEPROM_EN
            m_regs[i] = (m_ee_valid && i < 8) ? m_ee[i] : reg_default(i);
`else
            m_regs[i] = reg_default(i);
`endif
        end
    endtask

    task automatic model_frame(input logic [31:0] w, input int n, output int e_stb,
                               output int e_err, output bit chk, output logic [31:0] e_cap);
        e_stb = 0;
        e_err = 0;
        e_cap = '0;
        chk   = 1'b1;
        if (m_pend) begin
            if (n == 32) e_cap = {m_rd(m_addr), m_addr};
            else begin e_err = 1; chk = 1'b0; end
            m_pend = 1'b0;
        end else if (n != 32) begin
            e_err = 1;
        end else if (w[3:0] <= 4'd8) begin
            if (m_busy) e_err = 1;
            else begin m_regs[w[3:0]] = w[31:4]; e_stb = 1; end
        end else if (w[3:0] == 4'hE) begin
            m_pend = 1'b1;
            m_addr = w[7:4];
        end else if (w == 32'h1F) begin
`ifdef CDCE_RSP_EEPROM_EN
            if (m_busy) e_err = 1;
            else begin
                for (int i = 0; i < 8; i++) m_ee[i] = m_regs[i];
                m_ee_valid = 1'b1;
                m_busy     = 1'b1;
            end
`else
            e_err = 1;
`endif
        end else begin
            e_err = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek_check(input string name, input logic [3:0] a, input logic [27:0] exp);
        @(negedge clk);
        host_rd_addr = a;
        #1;
        check(name, 32'(host_rd_data), 32'(exp));
    endtask

    // Master side: MOSI LSB first, MISO shifted in at bit31 just before each SCLK rise.
    task automatic spi_frame(input logic [31:0] w, input int n, output logic [31:0] cap);
        cap = '0;
        @(negedge clk);
        spi_bus.spi_le = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < n; i++) begin
            spi_bus.spi_mosi = w[i % 32];
            wait_clk(HALF);
            cap = {spi_bus.spi_miso, cap[31:1]};
            spi_bus.spi_clk = 1'b1;
            wait_clk(HALF);
            spi_bus.spi_clk = 1'b0;
        end
        wait_clk(HALF);
        spi_bus.spi_le = 1'b1;
        wait_clk(12);
    endtask

    task automatic run_frame(input logic [31:0] w, input int n, input string tag);
        int          s0, e0, es, ee;
        bit          chk;
        logic [31:0] cap, ecap;
        s0 = stb_cnt;
        e0 = err_cnt;
        model_frame(w, n, es, ee, chk, ecap);
        spi_frame(w, n, cap);
        check({tag, " stb"}, 32'(stb_cnt - s0), 32'(es));
        check({tag, " err"}, 32'(err_cnt - e0), 32'(ee));
        if (chk) check({tag, " miso"}, cap, ecap);
        if (es == 1) check({tag, " wr_data"}, {last_data, last_addr}, w);
    endtask

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          exp_stb;
        int          exp_err;
        logic [31:0] exp_cap;
        logic [3:0]  peek_addr;
        logic [27:0] exp_peek;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          s0, e0, es, ee;
        bit          chk;
        logic [31:0] cap, ecap, rnd, w;
        int          n, kind, busy_cycles, err_before;

        vecs[0] = '{32'h81400320, 32, 1, 0, 32'h0,        4'd0, 28'h8140032};
        vecs[1] = '{32'h81400321, 32, 1, 0, 32'h0,        4'd1, 28'h8140032};
        vecs[2] = '{32'h0000001E, 32, 0, 0, 32'h0,        4'd1, 28'h8140032};
        vecs[3] = '{32'hA5A5A5A5, 32, 0, 0, 32'h81400321, 4'd5, reg_default(5)};
        vecs[4] = '{32'hFFFFFFF1, 20, 0, 1, 32'h0,        4'd1, 28'h8140032};
        vecs[5] = '{32'h12345679, 32, 0, 1, 32'h0,        4'd9, 28'h0};
        vecs[6] = '{32'h0000009E, 32, 0, 0, 32'h0,        4'd9, 28'h0};
        vecs[7] = '{32'h00000000, 32, 0, 0, 32'h00000009, 4'd0, 28'h8140032};
        vecs[8] = '{32'h0000003F, 32, 0, 1, 32'h0,        4'd3, reg_default(3)};

        m_ee_valid       = 1'b0;
        rst              = 1'b1;
        spi_bus.spi_clk  = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        spi_bus.spi_le   = 1'b1;
        host_rd_addr     = '0;
        model_reset();
        wait_clk(6);
        rst = 1'b0;
        wait_clk(4);

        check("reset stb",  32'(reg_wr_stb),     32'h0);
        check("reset err",  32'(frame_err),      32'h0);
        check("reset miso", 32'(spi_bus.spi_miso), 32'h0);
        check("reset busy", 32'(eeprom_busy),    32'h0);
        check("reset wr_data", {reg_wr_data, reg_wr_addr}, 32'h0);
        peek_check("reset reg0", 4'd0, reg_default(0));
        peek_check("reset reg8", 4'd8, reg_default(8));

        for (int v = 0; v < 9; v++) begin
            s0 = stb_cnt;
            e0 = err_cnt;
            model_frame(vecs[v].word, vecs[v].nbits, es, ee, chk, ecap);
            spi_frame(vecs[v].word, vecs[v].nbits, cap);
            check($sformatf("vec%0d stb", v), 32'(stb_cnt - s0), 32'(vecs[v].exp_stb));
            check($sformatf("vec%0d err", v), 32'(err_cnt - e0), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d miso", v), cap, vecs[v].exp_cap);
            if (vecs[v].exp_stb == 1)
                check($sformatf("vec%0d wr_data", v), {last_data, last_addr}, vecs[v].word);
            peek_check($sformatf("vec%0d peek", v), vecs[v].peek_addr, vecs[v].exp_peek);
        end

        for (int r = 0; r < 40; r++) begin
            rnd  = $urandom();
            kind = $urandom_range(0, 5);
            n    = 32;
            case (kind)
                0, 1: w = {rnd[27:0], 4'($urandom_range(0, 8))};
                2:    w = {rnd[31:8], 4'($urandom_range(0, 15)), 4'hE};
                3:    w = {rnd[31:4], 4'($urandom_range(9, 13))};
                4: begin
                    w = rnd;
                    n = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 31) : $urandom_range(33, 40);
                end
                default: begin
                    w = {rnd[31:4], 4'hF};
                    if (w == 32'h1F) w = 32'h2F;
                end
            endcase
            run_frame(w, n, $sformatf("rnd%0d", r));
            n = $urandom_range(0, 15);
            peek_check($sformatf("rnd%0d peek", r), 4'(n), m_rd(4'(n)));
        end

        if (m_pend) run_frame(32'h0, 32, "flush");

        busy_cycles = 0;
        fork
            begin
                repeat (2500) begin
                    @(negedge clk);
                    if (eeprom_busy) busy_cycles++;
                end
            end
            begin
                run_frame(32'h0000001F, 32, "eeprom cmd");
                run_frame(32'hABCDEF23, 32, "write in busy");
            end
        join
`ifdef CDCE_RSP_EEPROM_EN
        check("busy cycles", 32'(busy_cycles), 32'd1000);
`else
        check("busy cycles", 32'(busy_cycles), 32'd0);
`endif
        check("busy end", 32'(eeprom_busy), 32'h0);
        m_busy = 1'b0;
        peek_check("reg3 after eeprom", 4'd3, m_rd(4'd3));

        err_before = err_cnt;
        @(negedge clk);
        spi_bus.spi_le = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 16; i++) begin
            spi_bus.spi_mosi = 1'($urandom_range(0, 1));
            wait_clk(HALF);
            spi_bus.spi_clk = 1'b1;
            wait_clk(HALF);
            spi_bus.spi_clk = 1'b0;
        end
        rst            = 1'b1;
        spi_bus.spi_le = 1'b1;
        wait_clk(6);
        rst = 1'b0;
        model_reset();
        wait_clk(4);
        peek_check("post-rst reg0", 4'd0, m_rd(4'd0));
        run_frame(32'h12345672, 32, "post-rst write");
        check("aborted frame err", 32'(err_cnt - err_before), 32'h0);
        peek_check("post-rst reg2", 4'd2, 28'h1234567);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
